multicycle_control_unit: RTL and testbench
==========================================

MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 Parameter CNT_W, default 32: width of retired-instruction counter.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 opcode  input  7  instruction-register opcode field, stable from DECODE until the next FETCH.
REQ-005 zero  input  1  ALU zero flag.
REQ-006 mem_ready  input  1  memory completion handshake for fetch, load and store accesses.
REQ-007 pc_write  output  1  PC register enable, = pc_update | (branch & zero).
REQ-008 adr_src  output  1  memory address select: 0 PC, 1 result.
REQ-009 mem_write  output  1  data-memory write strobe.
REQ-010 ir_write  output  1  instruction-register enable.
REQ-011 result_src  output  2  result select: 00 alu_out, 01 read data, 10 ALU result.
REQ-012 alu_src_a  output  2  ALU A select: 00 PC, 01 old PC, 10 rs1.
REQ-013 alu_src_b  output  2  ALU B select: 00 rs2, 01 immediate, 10 constant 4.
REQ-014 alu_op  output  2  ALU class: 00 add, 01 subtract/compare, 10 funct-decoded.
REQ-015 imm_src  output  3  immediate format: 000 I, 001 S, 010 B, 011 J.
REQ-016 reg_write  output  1  register-file write enable.
REQ-017 illegal  output  1  sticky illegal-opcode flag.
REQ-018 instret  output  CNT_W  retired-instruction count.

Function
REQ-019 Moore FSM, states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL, TRAP; every output not listed for a state SHALL be 0.
REQ-020 FETCH: adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10; ir_write=pc_update=mem_ready; stays while mem_ready=0, else -> DECODE.
REQ-021 DECODE: alu_src_a=01, alu_src_b=01, alu_op=00; imm_src from opcode (0100011->001, 1100011->010, 1101111->011, else 000).
REQ-022 DECODE next: 0000011/0100011 -> MEMADR, 0110011 -> EXECR, 0010011 -> EXECI, 1100011 -> BEQ, 1101111 -> JAL, any other -> TRAP.
REQ-023 MEMADR: alu_src_a=10, alu_src_b=01, alu_op=00; -> MEMREAD for load, MEMWRITE for store.
REQ-024 MEMREAD: adr_src=1, result_src=00; waits on mem_ready, then -> MEMWB.
REQ-025 MEMWB: result_src=01, reg_write=1; -> FETCH.
REQ-026 MEMWRITE: adr_src=1, result_src=00, mem_write=1 held every cycle until mem_ready=1; -> FETCH.
REQ-027 EXECR: alu_src_a=10, alu_src_b=00, alu_op=10; EXECI: alu_src_a=10, alu_src_b=01, alu_op=10; both -> ALUWB.
REQ-028 ALUWB: result_src=00, reg_write=1; -> FETCH.
REQ-029 BEQ: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, branch=1; -> FETCH.
REQ-030 JAL: alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_update=1; -> ALUWB.
REQ-031 TRAP: absorbing, illegal=1, pc_write and all enables 0; exits only on reset.
REQ-032 instret increments by 1, modulo 2^CNT_W, on each transition into FETCH from MEMWB, MEMWRITE, ALUWB or BEQ.

Reset
REQ-033 reset=1 at any clock edge, including mid-wait or in TRAP, SHALL force state FETCH, instret=0 and illegal=0, overriding all other events in that cycle.

Configuration
REQ-034 Macro MCU_JAL_EN: when defined, JAL state and opcode 1101111 are supported as above.
REQ-035 Without MCU_JAL_EN, the JAL state SHALL NOT exist, and opcode 1101111 decodes to TRAP.

Verification
REQ-036 add (0110011), mem_ready=1: FETCH, DECODE, EXECR, ALUWB, FETCH; reg_write=1 exactly 1 cycle; instret 0->1.
REQ-037 lw (0000011), mem_ready low 3 cycles in MEMREAD: 5 states plus 3 wait cycles; reg_write with result_src=01 once; instret +1.
REQ-038 sw (0100011), mem_ready low 2 cycles in MEMWRITE: mem_write=1 for 3 consecutive cycles, reg_write never 1.
REQ-039 beq (1100011) with zero=1: pc_write=1 in BEQ; with zero=0: pc_write=0.
REQ-040 opcode 0000000: TRAP, illegal=1 held 10 cycles; reset pulse -> FETCH, illegal=0, instret=0.
REQ-041 CNT_W=4, 16 R-type instructions from reset: instret wraps to 0; jal (1101111) -> JAL then ALUWB with MCU_JAL_EN, TRAP without.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: multicycle RISC-V style control FSM with retired-instruction counter; JAL support under MCU_JAL_EN.
module multicycle_control_unit #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             adr_src,
  output logic             mem_write,
  output logic             ir_write,
  output logic [1:0]       result_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [2:0]       imm_src,
  output logic             reg_write,
  output logic             illegal,
  output logic [CNT_W-1:0] instret
);
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ,
`ifdef MCU_JAL_EN
    JAL,
`endif
    TRAP
  } state_t;
  state_t state, next;
  logic pc_update, branch, retire;
  assign pc_write = pc_update | (branch & zero);
  assign retire = next == FETCH && (state == MEMWB || state == MEMWRITE || state == ALUWB || state == BEQ);
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= FETCH;
      instret <= '0;
    end else begin
      state <= next;
      if (retire) instret <= instret + CNT_W'(1);
    end
  end
  always_comb begin
    next       = state;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    imm_src    = 3'b000;
    reg_write  = 1'b0;
    illegal    = 1'b0;
    pc_update  = 1'b0;
    branch     = 1'b0;
    case (state)
      FETCH: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = mem_ready;
        pc_update  = mem_ready;
        next       = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        imm_src   = opcode == OP_SW ? 3'b001 : opcode == OP_BEQ ? 3'b010 : opcode == OP_JAL ? 3'b011 : 3'b000;
        case (opcode)
          OP_LW, OP_SW: next = MEMADR;
          OP_R:         next = EXECR;
          OP_I:         next = EXECI;
          OP_BEQ:       next = BEQ;
`ifdef MCU_JAL_EN
          OP_JAL:       next = JAL;
`endif
          default:      next = TRAP;
        endcase
      end
      MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        next      = opcode == OP_LW ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        adr_src = 1'b1;
        next    = mem_ready ? MEMWB : MEMREAD;
      end
      MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        next       = FETCH;
      end
      MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        next      = mem_ready ? FETCH : MEMWRITE;
      end
      EXECR: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
        next      = ALUWB;
      end
      EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
        next      = ALUWB;
      end
      ALUWB: begin
        reg_write = 1'b1;
        next      = FETCH;
      end
      BEQ: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        branch    = 1'b1;
        next      = FETCH;
      end
`ifdef MCU_JAL_EN
      JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_update = 1'b1;
        next      = ALUWB;
      end
`endif
      TRAP: begin
        illegal = 1'b1;
        next    = TRAP;
      end
      default: next = FETCH;
    endcase
  end
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: builds each instruction's expected control sequence and checks it every cycle.
module tb_multicycle_control_unit;
  localparam int CW = 4;
  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RR = 7'b0110011, II = 7'b0010011;
  localparam logic [6:0] BQ = 7'b1100011, JL = 7'b1101111;
  logic clk = 1'b0, reset = 1'b1, zero = 1'b0, mem_ready = 1'b0;
  logic [6:0] opcode = '0;
  logic pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
  logic [2:0] imm_src;
  logic [CW-1:0] instret;
  logic chk = 1'b0;
  logic [16:0] exp_v;
  logic [CW-1:0] exp_cnt, cnt = '0;
  string tag;
  int nvec = 0, nerr = 0;
  multicycle_control_unit #(.CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write), .ir_write(ir_write),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .imm_src(imm_src), .reg_write(reg_write), .illegal(illegal), .instret(instret)
  );
  always #5 clk = ~clk;
  wire [16:0] act = {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a, alu_src_b, alu_op, imm_src, reg_write, illegal};
  always @(negedge clk) if (chk) begin
    nvec++;
    if (act !== exp_v) begin
      nerr++;
      $display("FAIL %s ctrl: got %b want %b (t=%0t)", tag, act, exp_v, $time);
    end
    nvec++;
    if (instret !== exp_cnt) begin
      nerr++;
      $display("FAIL %s instret: got %0d want %0d (t=%0t)", tag, instret, exp_cnt, $time);
    end
  end
  function automatic logic [16:0] mk(input logic pcw, adr, mw, irw, input logic [1:0] rs, a, b, op,
                                     input logic [2:0] imm, input logic rw, ill);
    return {pcw, adr, mw, irw, rs, a, b, op, imm, rw, ill};
  endfunction
  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction
  task automatic step(input logic mr, input logic z, input logic [16:0] e, input string t);
    mem_ready = mr;
    zero = z;
    exp_v = e;
    exp_cnt = cnt;
    tag = t;
    chk = 1'b1;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    chk = 1'b0;
    reset = 1'b1;
    mem_ready = rb();
    @(posedge clk);
    #1;
    reset = 1'b0;
    cnt = '0;
  endtask
  task automatic pin(input logic [31:0] got, input logic [31:0] want, input string t);
    nvec++;
    if (got !== want) begin
      nerr++;
      $display("FAIL %s: got %0d want %0d", t, got, want);
    end
  endtask
  task automatic wb();
    step(rb(), rb(), mk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1, 0), "aluwb");
    cnt++;
  endtask
  task automatic run(input logic [6:0] op, input int fw, input int mw, input logic bz);
    logic [2:0] imm;
    for (int i = 0; i < fw; i++) begin
      opcode = 7'($urandom);
      step(0, rb(), mk(0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0, 0), "fetch_wait");
    end
    opcode = 7'($urandom);
    step(1, rb(), mk(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0, 0), "fetch");
    opcode = op;
    imm = op == SW ? 3'b001 : op == BQ ? 3'b010 : op == JL ? 3'b011 : 3'b000;
    step(rb(), rb(), mk(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, imm, 0, 0), "decode");
    case (op)
      LW, SW: begin
        step(rb(), rb(), mk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 0, 0), "memadr");
        for (int i = 0; i <= mw; i++)
          step(i == mw, rb(), mk(0, 1, op == SW, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0), op == SW ? "memwrite" : "memread");
        if (op == LW) step(rb(), rb(), mk(0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000, 1, 0), "memwb");
        cnt++;
      end
      RR, II: begin
        step(rb(), rb(), mk(0, 0, 0, 0, 2'b00, 2'b10, op == II ? 2'b01 : 2'b00, 2'b10, 3'b000, 0, 0), "exec");
        wb();
      end
      BQ: begin
        step(rb(), bz, mk(bz, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b01, 3'b000, 0, 0), "beq");
        cnt++;
      end
`ifdef MCU_JAL_EN
      JL: begin
        step(rb(), rb(), mk(1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00, 3'b000, 0, 0), "jal");
        wb();
      end
`endif
      default: begin
        for (int i = 0; i < 10; i++)
          step(rb(), rb(), mk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0, 1), "trap");
        do_reset();
      end
    endcase
  endtask
  initial begin
    logic [6:0] op;
    do_reset();
    do_reset();
    step(0, 1, {4'b0000, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 2'b00}, "reset_fetch");
    run(RR, 0, 0, 0);
    pin(32'(instret), 1, "add_instret");
    run(LW, 0, 3, 0);
    run(SW, 1, 2, 0);
    run(BQ, 0, 0, 1);
    run(BQ, 0, 0, 0);
    run(II, 2, 0, 0);
    do_reset();
    for (int i = 0; i < 16; i++) run(RR, 0, 0, 0);
    pin(32'(instret), 0, "wrap_instret");
    run(RR, 0, 0, 0);
    run(JL, 0, 0, 0);
    run(RR, 0, 0, 0);
    run(7'b0000000, 0, 0, 0);
    pin(32'(instret), 0, "trap_reset_instret");
    pin(32'(illegal), 0, "trap_reset_illegal");
    for (int n = 0; n < 80; n++) begin
      case ($urandom_range(0, 7))
        0: op = LW;
        1: op = SW;
        2: op = RR;
        3: op = II;
        4: op = BQ;
        5: op = JL;
        default: op = 7'($urandom);
      endcase
      run(op, $urandom_range(0, 2), $urandom_range(0, 3), rb());
    end
    chk = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
